// File: rtl/run_length_meter.sv
// Measures cycles between successive change pulses and queues each completed run
// length in a small FIFO. Optional min/max tracking is enabled by RLM_MINMAX_EN.
module run_length_meter #(
  parameter int CNT_W = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             dif,
  output logic [CNT_W-1:0] len_data,
  output logic             len_sat,
  output logic             len_valid,
  input  logic             len_ready,
  output logic             drop,
  output logic [CNT_W-1:0] min_len,
  output logic [CNT_W-1:0] max_len
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] MAXC = '1;
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [AW:0]      FULL = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic             push;

  logic [CNT_W:0]   mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             full, pop, wr;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    push    = 1'b0;
    if (clr) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (en && dif) begin
            state_d = RUN;
            cnt_d   = ONE;
            sat_d   = 1'b0;
          end
        end
        RUN: begin
          if (!en) begin
            state_d = IDLE;
          end else if (dif) begin
            push  = 1'b1;
            cnt_d = ONE;
            sat_d = 1'b0;
          end else begin
            if (cnt_q != MAXC) cnt_d = cnt_q + ONE;
            // sat flags any run that reached the ceiling, including exactly MAXC
            sat_d = sat_q | (cnt_q >= (MAXC - ONE));
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  assign full      = (count == FULL);
  assign len_valid = (count != '0);
  assign pop       = len_valid && len_ready;
  // a pop frees the slot in the same edge, so a full FIFO still accepts the push
  assign wr        = push && (!full || pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      drop   <= 1'b0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      drop   <= 1'b0;
    end else begin
      if (wr) begin
        mem[wr_ptr] <= {sat_q, cnt_q};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({wr, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (push && full && !pop) drop <= 1'b1;
    end
  end

  assign {len_sat, len_data} = mem[rd_ptr];

`ifdef RLM_MINMAX_EN
  logic [CNT_W-1:0] min_q, max_q;

  // every completed run counts, whether or not the FIFO accepted it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      min_q <= '1;
      max_q <= '0;
    end else if (clr) begin
      min_q <= '1;
      max_q <= '0;
    end else if (push) begin
      if (cnt_q < min_q) min_q <= cnt_q;
      if (cnt_q > max_q) max_q <= cnt_q;
    end
  end

  assign min_len = min_q;
  assign max_len = max_q;
`else
  assign min_len = '0;
  assign max_len = '0;
`endif

endmodule
